// File: rtl/muldiv_unit_pkg.sv
// Package for the RV32M multiply/divide unit.
// Holds the default widths, the RV32M instruction constants (opcode, funct7,
// funct3 encodings) and the operand signedness rules shared by the unit.
package muldiv_unit_pkg;

  localparam int XLEN_DEF    = 32;
  localparam int RADDR_W_DEF = 5;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    F3_MUL    = 3'b000,
    F3_MULH   = 3'b001,
    F3_MULHSU = 3'b010,
    F3_MULHU  = 3'b011,
    F3_DIV    = 3'b100,
    F3_DIVU   = 3'b101,
    F3_REM    = 3'b110,
    F3_REMU   = 3'b111
  } muldiv_op_e;

  // rs1 is signed for MUL, MULH, MULHSU, DIV and REM.
  function automatic logic op_a_signed(input logic [2:0] f3);
    return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_MULHSU) ||
           (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  // rs2 is signed for MUL, MULH, DIV and REM.
  function automatic logic op_b_signed(input logic [2:0] f3);
    return (f3 == F3_MUL) || (f3 == F3_MULH) ||
           (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit.
// Accepts one operation when idle, runs XLEN shift-add (multiply) or
// restoring (divide) steps, then presents the result on the register-file
// write port for exactly one cycle.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start           request, accepted only while busy=0
//   funct3          RV32M operation select
//   rd              destination register
//   op_a, op_b      rs1 / rs2 values
//   busy            high from the accept edge until the DONE cycle ends
//   done            one-cycle completion pulse
//   waddr, wdata    register-file write address / data (hold between ops)
//   we              register-file write enable, never asserted for rd=0
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int RADDR_W = RADDR_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [2:0]         funct3,
  input  logic [RADDR_W-1:0] rd,
  input  logic [XLEN-1:0]    op_a,
  input  logic [XLEN-1:0]    op_b,
  output logic               busy,
  output logic               done,
  output logic [RADDR_W-1:0] waddr,
  output logic [XLEN-1:0]    wdata,
  output logic               we
);

  localparam int CNT_W = $clog2(XLEN);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic [2:0]         fn_q;
  logic [RADDR_W-1:0] rd_q;
  logic [XLEN-1:0]    mag_a;     // multiplicand magnitude
  logic [XLEN-1:0]    mag_b;     // divisor magnitude
  logic               neg_main;  // negate product / quotient in DONE
  logic               neg_rem;   // negate remainder in DONE
  // Multiply: full product, multiplier bits consumed from bit 0.
  // Divide: low half holds dividend shifting out / quotient shifting in.
  logic [2*XLEN-1:0]  acc;
  logic [XLEN:0]      rem;
  logic [RADDR_W-1:0] waddr_q;
  logic [XLEN-1:0]    wdata_q;

  // Accept-time operand decode.
  logic            sa, sb, is_div, div_zero, div_ovf, special;
  logic [XLEN-1:0] abs_a, abs_b;

  assign is_div   = funct3[2];
  assign sa       = op_a_signed(funct3) & op_a[XLEN-1];
  assign sb       = op_b_signed(funct3) & op_b[XLEN-1];
  assign abs_a    = sa ? (XLEN'(0) - op_a) : op_a;
  assign abs_b    = sb ? (XLEN'(0) - op_b) : op_b;
  assign div_zero = is_div && (op_b == '0);
  assign div_ovf  = is_div && op_b_signed(funct3) && (op_a == INT_MIN) && (op_b == '1);
  assign special  = div_zero || div_ovf;

  // One iteration step for each algorithm.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     div_shift;
  logic              div_ge;
  logic [XLEN:0]     div_rem_next;

  assign mul_sum      = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mag_a} : '0);
  assign mul_next     = {mul_sum, acc[XLEN-1:1]};
  assign div_shift    = {rem[XLEN-1:0], acc[XLEN-1]};
  assign div_ge       = div_shift >= {1'b0, mag_b};
  assign div_rem_next = div_ge ? (div_shift - {1'b0, mag_b}) : div_shift;

  // Sign correction and result selection for the DONE cycle.
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, result;

  assign prod_fix = neg_main ? ((2*XLEN)'(0) - acc) : acc;
  assign quo_fix  = neg_main ? (XLEN'(0) - acc[XLEN-1:0]) : acc[XLEN-1:0];
  assign rem_fix  = neg_rem  ? (XLEN'(0) - rem[XLEN-1:0]) : rem[XLEN-1:0];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    result = prod_fix[XLEN-1:0];
    case (fn_q)
      F3_MULH, F3_MULHSU, F3_MULHU: result = prod_fix[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:              result = quo_fix;
      F3_REM, F3_REMU:              result = rem_fix;
      default:                      result = prod_fix[XLEN-1:0];
    endcase
  end

  // NOTE: all state, including the operand registers, is cleared by reset so an aborted op leaves nothing behind.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      fn_q     <= '0;
      rd_q     <= '0;
      mag_a    <= '0;
      mag_b    <= '0;
      neg_main <= 1'b0;
      neg_rem  <= 1'b0;
      acc      <= '0;
      rem      <= '0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            fn_q  <= funct3;
            rd_q  <= rd;
            mag_a <= abs_a;
            mag_b <= abs_b;
            cnt   <= CNT_W'(XLEN-1);
            if (special) begin
              // Result is fixed at accept; DONE applies no sign correction.
              state    <= S_DONE;
              neg_main <= 1'b0;
              neg_rem  <= 1'b0;
              acc      <= {{XLEN{1'b0}}, (div_zero ? {XLEN{1'b1}} : op_a)};
              rem      <= {1'b0, (div_zero ? op_a : {XLEN{1'b0}})};
            end else begin
              state    <= S_CALC;
              neg_main <= sa ^ sb;
              neg_rem  <= sa;
              acc      <= {{XLEN{1'b0}}, (is_div ? abs_a : abs_b)};
              rem      <= '0;
            end
          end
        end
        S_CALC: begin
          if (fn_q[2]) begin
            rem             <= div_rem_next;
            acc[XLEN-1:0]   <= {acc[XLEN-2:0], div_ge};
          end else begin
            acc <= mul_next;
          end
          cnt <= cnt - 1'b1;
          if (cnt == '0) state <= S_DONE;
        end
        S_DONE: begin
          waddr_q <= rd_q;
          wdata_q <= result;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy  = (state != S_IDLE);
  assign done  = (state == S_DONE);
  assign we    = done && (rd_q != '0);
  assign waddr = done ? rd_q : waddr_q;
  assign wdata = done ? result : wdata_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Testbench for muldiv_unit: directed and randomized RV32M operations,
// an arithmetic reference model, and a scoreboard queue drained by an
// independent monitor that checks every done pulse.
module tb_muldiv_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic [31:0] op_a, op_b;
  logic        busy, done, we;
  logic [4:0]  waddr;
  logic [31:0] wdata;

  muldiv_unit #(.XLEN(32), .RADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3), .rd(rd),
    .op_a(op_a), .op_b(op_b), .busy(busy), .done(done),
    .waddr(waddr), .wdata(wdata), .we(we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    int          accept_cyc;
    int          lat;
  } exp_t;

  exp_t sb_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: plain 64-bit arithmetic following the RV32M rules.
  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ub;
    logic [63:0] p;
    logic ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ub  = longint'({32'b0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'b000: begin p = 64'(sa * sb); return p[31:0]; end
      3'b001: begin p = 64'(sa * sb); return p[63:32]; end
      3'b010: begin p = 64'(sa * ub); return p[63:32]; end
      3'b011: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        return 32'(sa / sb);
      end
      3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        return 32'(sa % sb);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed_div;
    signed_div = (f == 3'b100) || (f == 3'b110);
    if (f[2] && (b == 0 || (signed_div && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
      return 1;
    return 33;
  endfunction

  // Wait (bounded) for the unit to be idle, then present one request.
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] d, input bit push);
    int n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++;
      failures++;
      $display("FAIL idle_timeout: busy still 1 after %0d cycles, required 0", n);
    end
    start = 1'b1; funct3 = f; op_a = a; op_b = b; rd = d;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (push) begin
      e.rd = d;
      e.data = ref_model(f, a, b);
      e.accept_cyc = cyc;
      e.lat = ref_latency(f, a, b);
      sb_q.push_back(e);
    end
  endtask

  // Monitor: compares every done pulse against the oldest expectation.
  bit prev_done = 0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (prev_done) check("busy_drop_after_done", {31'b0, busy}, 32'd0);
      prev_done = rst_n && done;
      if (rst_n && done) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: waddr=%0d wdata=0x%08h with no pending op", waddr, wdata);
        end else begin
          e = sb_q.pop_front();
          check("wdata", wdata, e.data);
          check("waddr", {27'b0, waddr}, {27'b0, e.rd});
          check("we", {31'b0, we}, {31'b0, (e.rd != 0)});
          check("busy_in_done", {31'b0, busy}, 32'd1);
          check("latency", 32'(cyc - e.accept_cyc + 1), 32'(e.lat));
        end
      end
    end
  end

  initial begin
    int n;
    int dones;
    logic [2:0]  f;
    logic [31:0] a, b;
    rst_n = 1'b0; start = 1'b0; funct3 = '0; rd = '0; op_a = '0; op_b = '0;
    repeat (3) @(negedge clk);
    check("reset_busy",  {31'b0, busy},  32'd0);
    check("reset_done",  {31'b0, done},  32'd0);
    check("reset_we",    {31'b0, we},    32'd0);
    check("reset_waddr", {27'b0, waddr}, 32'd0);
    check("reset_wdata", wdata,          32'd0);
    rst_n = 1'b1;

    // Directed operations.
    issue(3'b000, 32'd7,          32'hFFFF_FFFD, 5'd5,  1);
    issue(3'b001, 32'h8000_0000,  32'h8000_0000, 5'd6,  1);
    issue(3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd7,  1);
    issue(3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd8,  1);
    issue(3'b100, 32'hFFFF_FFEC,  32'd3,         5'd9,  1);
    issue(3'b110, 32'hFFFF_FFEC,  32'd3,         5'd10, 1);
    issue(3'b101, 32'd20,         32'd3,         5'd11, 1);
    issue(3'b111, 32'd20,         32'd3,         5'd12, 1);
    issue(3'b100, 32'd42,         32'd0,         5'd13, 1);
    issue(3'b111, 32'd42,         32'd0,         5'd14, 1);
    issue(3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 5'd15, 1);
    issue(3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 5'd16, 1);
    issue(3'b000, 32'd3,          32'd4,         5'd0,  1);

    // A start pulse during CALC must be ignored.
    issue(3'b000, 32'h0000_1234,  32'h0000_5678, 5'd17, 1);
    repeat (5) @(negedge clk);
    check("busy_mid_calc", {31'b0, busy}, 32'd1);
    start = 1'b1; funct3 = 3'b100; op_a = 32'd9; op_b = 32'd3; rd = 5'd18;
    @(posedge clk);
    #1;
    start = 1'b0;

    // Randomized operations with biased corner operands.
    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0: begin a = $urandom; b = 32'd0; end
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = 32'($urandom_range(0, 50)) - 32'd25; b = 32'($urandom_range(1, 9)); end
        default: begin a = $urandom; b = $urandom; end
      endcase
      issue(f, a, b, 5'($urandom_range(0, 31)), 1);
    end

    // Reset in the middle of CALC discards the operation.
    issue(3'b000, 32'h0000_00FF, 32'h0000_0101, 5'd20, 0);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_busy",  {31'b0, busy}, 32'd0);
    check("midreset_done",  {31'b0, done}, 32'd0);
    check("midreset_we",    {31'b0, we},   32'd0);
    check("midreset_wdata", wdata,         32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || we) dones++;
    end
    check("no_writeback_after_reset", 32'(dones), 32'd0);

    // One more op after reset to confirm recovery.
    issue(3'b101, 32'd100, 32'd7, 5'd21, 1);

    n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
